// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding, instruction opcodes, IR capture pattern and the TAP next-state function
package jtag_pkg;
  typedef enum logic [3:0] {
    EX2_DR   = 4'h0,
    EX1_DR   = 4'h1,
    SHIFT_DR = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EX2_IR   = 4'h8,
    EX1_IR   = 4'h9,
    SHIFT_IR = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_e;
  localparam logic [3:0] OP_IDCODE = 4'h1;
  localparam logic [3:0] OP_USER   = 4'h2;
  localparam logic [3:0] OP_BYPASS = 4'hF;
  localparam logic [1:0] IR_CAPTURE = 2'b01;
  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    case (s)
      TLR:      return tms ? TLR    : RTI;
      RTI:      return tms ? SEL_DR : RTI;
      SEL_DR:   return tms ? SEL_IR : CAP_DR;
      CAP_DR:   return tms ? EX1_DR : SHIFT_DR;
      SHIFT_DR: return tms ? EX1_DR : SHIFT_DR;
      EX1_DR:   return tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: return tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   return tms ? UPD_DR : SHIFT_DR;
      UPD_DR:   return tms ? SEL_DR : RTI;
      SEL_IR:   return tms ? TLR    : CAP_IR;
      CAP_IR:   return tms ? EX1_IR : SHIFT_IR;
      SHIFT_IR: return tms ? EX1_IR : SHIFT_IR;
      EX1_IR:   return tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: return tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   return tms ? UPD_IR : SHIFT_IR;
      UPD_IR:   return tms ? SEL_DR : RTI;
      default:  return TLR;
    endcase
  endfunction
endpackage

// File: rtl/jtag_sync_edge.sv
// jtag_sync_edge: 2-flop synchronizer for a bundle of pins; rise/fall pulses are taken from bit 0
module jtag_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         rise,
  output logic         fall
);
  logic [W-1:0] meta;
  logic         prev;
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
      prev <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
      prev <= q[0];
    end
  end
  assign rise = q[0] & ~prev;
  assign fall = ~q[0] & prev;
endmodule

// File: rtl/jtag_tap.sv
// jtag_tap: oversampled IEEE 1149.1 TAP with USER and BYPASS data registers.
// Define JTAG_TAP_IDCODE_EN to include the IDCODE register (opcode 4'h1, selected after TLR/reset).
module jtag_tap
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH   = 4,
  parameter int          USER_WIDTH = 8,
  parameter logic [31:0] IDCODE     = 32'h1000_0001
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tck,
  input  logic                  tms,
  input  logic                  tdi,
  output logic                  tdo,
  output logic                  rtck,
  input  logic [USER_WIDTH-1:0] i_pins,
  output logic [USER_WIDTH-1:0] o_pins,
  output logic [3:0]            state
);
  if (IR_WIDTH < 2 || !IDCODE[0]) begin : g_bad_cfg
    $error("jtag_tap: IR_WIDTH must be >= 2 and IDCODE[0] must be 1");
  end
  logic [2:0]            pins_s;
  logic                  tck_s, tms_s, tdi_s, rise, fall;
  tap_state_e            cur, nxt;
  logic [IR_WIDTH-1:0]   ir, ir_sr;
  logic [USER_WIDTH-1:0] user_sr;
  logic                  bypass_sr, sel_idcode, sel_user, sel_bypass, idcode_lsb, dr_lsb;
  jtag_sync_edge #(.W(3)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    ({tdi, tms, tck}),
    .q    (pins_s),
    .rise (rise),
    .fall (fall)
  );
  assign {tdi_s, tms_s, tck_s} = pins_s;
  assign rtck  = tck_s;
  assign state = cur;
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_RESET = IR_WIDTH'(OP_IDCODE);
  logic [31:0] idcode_sr;
  assign sel_idcode = ir == IR_WIDTH'(OP_IDCODE);
  assign idcode_lsb = idcode_sr[0];
  always_ff @(posedge clk) begin
    if (reset) idcode_sr <= '0;
    else if (rise && sel_idcode && cur == CAP_DR) idcode_sr <= IDCODE;
    else if (rise && sel_idcode && cur == SHIFT_DR) idcode_sr <= {tdi_s, idcode_sr[31:1]};
  end
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET = IR_WIDTH'(OP_BYPASS);
  assign sel_idcode = 1'b0;
  assign idcode_lsb = 1'b0;
`endif
  assign sel_user   = ir == IR_WIDTH'(OP_USER);
  assign sel_bypass = ~sel_idcode & ~sel_user;
  assign dr_lsb     = sel_idcode ? idcode_lsb : sel_user ? user_sr[0] : bypass_sr;
  always_comb nxt = tap_next(cur, tms_s);
  // All TAP actions belong to the state being left on a rising tck
  always_ff @(posedge clk) begin
    if (reset) begin
      cur       <= TLR;
      ir        <= IR_RESET;
      ir_sr     <= '0;
      user_sr   <= '0;
      bypass_sr <= 1'b0;
      o_pins    <= '0;
      tdo       <= 1'b0;
    end else if (rise) begin
      cur <= nxt;
      if (nxt == TLR) ir <= IR_RESET;
      else if (cur == UPD_IR) ir <= ir_sr;
      if (cur == CAP_IR) ir_sr <= IR_WIDTH'(IR_CAPTURE);
      else if (cur == SHIFT_IR) ir_sr <= {tdi_s, ir_sr[IR_WIDTH-1:1]};
      if (sel_user && cur == CAP_DR) user_sr <= i_pins;
      else if (sel_user && cur == SHIFT_DR) user_sr <= {tdi_s, user_sr[USER_WIDTH-1:1]};
      if (sel_bypass && cur == CAP_DR) bypass_sr <= 1'b0;
      else if (sel_bypass && cur == SHIFT_DR) bypass_sr <= tdi_s;
      if (sel_user && cur == UPD_DR) o_pins <= user_sr;
    end else if (fall) begin
      tdo <= cur == SHIFT_IR ? ir_sr[0] : cur == SHIFT_DR ? dr_lsb : 1'b0;
    end
  end
endmodule
